serial_reg_slave: RTL
=====================

SERIAL_REG_SLAVE -- requirements
Module: serial_reg_slave

Interface
REQ-001 Parameters SHALL be:
  - DATA_WIDTH, default 8, data bits per transfer.
  - ADDRS_WIDTH, default 12, local address bits received after slave selection.
  - REG_AW, default 4, register-file index width (2^REG_AW entries).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk  in  1  sole clock; all logic on rising edge.
  - rst  in  1  synchronous reset, active-high.
  - arbiter_cmd_in  in  1  select from bus_controller; 1 = this slave addressed.
  - rd_wrt  in  1  direction from master; 1 = write, 0 = read.
  - bus_util  in  1  bus in use, active-low (0 = transfer in progress).
  - data_bus_in  in  1  serial bus sample.
  - data_bus_out  out  1  serial read data.
  - data_bus_oe  out  1  1 = drive data_bus_out onto bus.
  - busy_out  out  1  1 = transaction in progress; to bus_controller.
  - last_data  out  DATA_WIDTH  last written or read byte, for seven-segment display.
  - parity_err  out  1  sticky parity-error flag.
  - state  out  4  FSM state code, for debug display.

Function
REQ-003 FSM states and codes SHALL be IDLE=0, RX_ADDR=1, RX_DATA=2, WRITE=3, TURN=4, TX_DATA=5.
REQ-004 IDLE: on an edge with arbiter_cmd_in=1 and bus_util=0, latch rd_wrt, go to RX_ADDR, set busy_out=1 from the next cycle.
REQ-005 arbiter_cmd_in SHALL be ignored outside IDLE.
REQ-006 RX_ADDR: capture data_bus_in LSB-first on ADDRS_WIDTH consecutive edges, then go to RX_DATA on write or TURN on read.
REQ-007 RX_DATA: capture DATA_WIDTH bits LSB-first (plus one parity bit under REQ-016), then go to WRITE.
REQ-008 WRITE (one cycle): store the byte at reg[addr[REG_AW-1:0]], update last_data, return to IDLE with busy_out=0 on the following cycle.
REQ-009 Address out of range (any addr bit at or above REG_AW nonzero): write SHALL be discarded, last_data unchanged.
REQ-010 TURN (one cycle, data_bus_oe=0): load the shift register with the addressed byte, or 0 if out of range.
REQ-011 TX_DATA: data_bus_oe=1 for exactly DATA_WIDTH cycles (plus one under REQ-016), data_bus_out = bit i in cycle i LSB-first, last_data updated on entry, then IDLE.
REQ-012 data_bus_oe SHALL be 0 in every state other than TX_DATA; data_bus_out SHALL be 0 whenever data_bus_oe=0.
REQ-013 Abort: bus_util=1 observed in any non-IDLE state SHALL force IDLE next cycle, clear busy_out and data_bus_oe, and suppress any pending write.
REQ-014 Abort and WRITE in the same cycle: abort wins, no write.
REQ-015 Bit counter SHALL be sized to count to ADDRS_WIDTH and SHALL clear on every state change.

Reset
REQ-016 (Parity behaviour is specified under Configuration; it is numbered here only to keep REQ numbering monotonic.)
REQ-017 On rst=1 at an edge, the following SHALL be forced regardless of state, including mid-transfer:
  - state=IDLE;
  - busy_out, data_bus_oe, data_bus_out, parity_err = 0;
  - last_data = 0;
  - all register-file entries = 0.

Configuration
REQ-018 Macro SERIAL_REG_SLAVE_PARITY_EN defined:
  - write: one even-parity bit follows data; on mismatch the write is discarded and parity_err=1 until rst.
  - read: an even-parity bit is sent after data in one extra TX_DATA cycle.
REQ-019 Macro SERIAL_REG_SLAVE_PARITY_EN undefined: no parity bit in either direction, and parity_err SHALL be tied 0.

Verification
REQ-020 Reset then idle: busy_out=0, data_bus_oe=0, state=0, last_data=0.
REQ-021 Write then read back:
  - write addr 12'h005 data 8'hE7 -> busy_out high for 1+12+8+1 cycles, last_data=8'hE7;
  - read addr 12'h005 -> after 1 TURN cycle, data_bus_oe high 8 cycles, serial stream 1,1,1,0,0,1,1,1.
REQ-022 Out-of-range:
  - write addr 12'h015 data 8'h99 -> no store;
  - read addr 12'h015 -> 8 zero bits;
  - read addr 12'h005 still returns 8'hE7.
REQ-023 Abort mid-transfer: write to addr 12'h003, raise bus_util after data bit 3 -> IDLE next cycle, busy_out=0, reg[3] stays 0.
REQ-024 Select while busy: pulse arbiter_cmd_in during RX_DATA -> ignored, current transaction completes normally.
REQ-025 With SERIAL_REG_SLAVE_PARITY_EN:
  - write 8'h03 with parity bit 1 -> no store, parity_err=1;
  - write 8'h03 with parity bit 0 -> stored;
  - read of that address -> 9 bits, ninth bit 0.

Source files
------------

// File: rtl/serial_reg_slave.sv
// Bit-serial register-file slave: shifts in address and write data LSB-first and shifts read data back out.
// Optional even-parity bit on data in both directions, enabled by defining SERIAL_REG_SLAVE_PARITY_EN.
module serial_reg_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDRS_WIDTH = 12,
    parameter int REG_AW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arbiter_cmd_in,
    input  logic                  rd_wrt,
    input  logic                  bus_util,
    input  logic                  data_bus_in,
    output logic                  data_bus_out,
    output logic                  data_bus_oe,
    output logic                  busy_out,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic                  parity_err,
    output logic [3:0]            state
);

`ifdef SERIAL_REG_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SH_W    = DATA_WIDTH + PAR_BITS;
    localparam int CNT_MAX = (ADDRS_WIDTH > SH_W) ? ADDRS_WIDTH : SH_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int NREG    = 1 << REG_AW;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RX_ADDR = 4'd1,
        RX_DATA = 4'd2,
        WRITE   = 4'd3,
        TURN    = 4'd4,
        TX_DATA = 4'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [SH_W-1:0]        sh_q, sh_d;
    logic                   rdwr_q, rdwr_d;
    logic                   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  last_q, last_d;
    logic [DATA_WIDTH-1:0]  regs_q [NREG];

    logic                   abort;
    logic                   in_range;
    logic                   par_ok;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  rd_byte;

`ifdef SERIAL_REG_SLAVE_PARITY_EN
    function automatic logic even_par(input logic [DATA_WIDTH-1:0] b);
        return ^b;
    endfunction

    // Data plus its parity bit must carry an even number of ones.
    assign par_ok = ~(^sh_q);
`else
    assign par_ok = 1'b1;
`endif

    assign abort    = (state_q != IDLE) && bus_util;
    assign in_range = (addr_q[ADDRS_WIDTH-1:REG_AW] == '0);
    assign rd_byte  = in_range ? regs_q[addr_q[REG_AW-1:0]] : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        rdwr_d  = rdwr_q;
        last_d  = last_q;
        wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arbiter_cmd_in && !bus_util) begin
                    rdwr_d  = rd_wrt;
                    state_d = RX_ADDR;
                end
            end
            RX_ADDR: begin
                addr_d = {data_bus_in, addr_q[ADDRS_WIDTH-1:1]};
                if (cnt_q == CNT_W'(ADDRS_WIDTH - 1)) begin
                    state_d = rdwr_q ? RX_DATA : TURN;
                end
            end
            RX_DATA: begin
                sh_d = {data_bus_in, sh_q[SH_W-1:1]};
                if (cnt_q == CNT_W'(SH_W - 1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (in_range && par_ok) begin
                    wr_en  = 1'b1;
                    last_d = sh_q[DATA_WIDTH-1:0];
                end
            end
            TURN: begin
`ifdef SERIAL_REG_SLAVE_PARITY_EN
                sh_d = {even_par(rd_byte), rd_byte};
`else
                sh_d = rd_byte;
`endif
                last_d  = rd_byte;
                state_d = TX_DATA;
            end
            TX_DATA: begin
                sh_d = sh_q >> 1;
                if (cnt_q == CNT_W'(SH_W - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A released bus kills the transaction, including a write due this cycle.
        if (abort) begin
            state_d = IDLE;
            wr_en   = 1'b0;
            last_d  = last_q;
        end
    end

    assign cnt_d  = ((state_d != state_q) || (state_d == IDLE)) ? '0 : cnt_q + CNT_W'(1);
    // Busy holds one extra cycle after a normal completion, but drops at once on abort.
    assign busy_d = (state_d != IDLE) || ((state_q != IDLE) && !abort);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            if (wr_en) begin
                regs_q[addr_q[REG_AW-1:0]] <= sh_q[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        sh_q   <= sh_d;
        rdwr_q <= rdwr_d;
    end

`ifdef SERIAL_REG_SLAVE_PARITY_EN
    logic perr_q, perr_d;

    assign perr_d = perr_q | ((state_q == WRITE) && !abort && !par_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_bus_oe  = (state_q == TX_DATA);
    assign data_bus_out = data_bus_oe & sh_q[0];
    assign busy_out     = busy_q;
    assign last_data    = last_q;
    assign state        = state_q;

endmodule
